// File: rtl/addend_vector_loader.sv
`default_nettype none
// ============================================================================
// Module   : addend_vector_loader
// Purpose  : Packs a valid/ready sample stream into LENGTH-wide addend vectors
//            for the adder tree, with an independent sequential running sum.
// Revision : 1.0
// ============================================================================
module addend_vector_loader #(
    parameter int DATA_WIDTH = 5,
    parameter int LENGTH     = 9,
    parameter int OUT_WIDTH  = DATA_WIDTH + $clog2(LENGTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] in_sample,
    input  logic                         in_sample_valid,
    output logic                         out_sample_ready,
    input  logic                         in_flush,
    output logic signed [DATA_WIDTH-1:0] out_addends [LENGTH],
    output logic signed [OUT_WIDTH-1:0]  out_running_sum,
    output logic [$clog2(LENGTH+1)-1:0]  out_count,
    output logic                         out_vector_valid,
    input  logic                         in_vector_ready
);

    localparam int CW = $clog2(LENGTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(LENGTH - 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t state;
    logic   sample_accept;
    logic   vector_accept;

    // Ready is gated by rst and flush so a sample is never taken in a cycle
    // whose state update is being overridden.
    assign out_sample_ready = (state == FILL) && !rst && !in_flush;
    assign sample_accept    = in_sample_valid && out_sample_ready;
    assign vector_accept    = out_vector_valid && in_vector_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= FILL;
            out_count        <= '0;
            out_running_sum  <= '0;
            out_vector_valid <= 1'b0;
            for (int i = 0; i < LENGTH; i++) begin
                out_addends[i] <= '0;
            end
        end else if (in_flush) begin
            // Addend slots keep stale data; only the fill pointer and sum clear.
            state            <= FILL;
            out_count        <= '0;
            out_running_sum  <= '0;
            out_vector_valid <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (sample_accept) begin
                        for (int i = 0; i < LENGTH; i++) begin
                            if (out_count == CW'(i)) begin
                                out_addends[i] <= in_sample;
                            end
                        end
                        out_running_sum <= out_running_sum + OUT_WIDTH'(in_sample);
                        out_count       <= out_count + CW'(1);
                        if (out_count == LAST_IDX) begin
                            state            <= FULL;
                            out_vector_valid <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (vector_accept) begin
                        state            <= FILL;
                        out_count        <= '0;
                        out_running_sum  <= '0;
                        out_vector_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addend_vector_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_addend_vector_loader
// Purpose  : Scoreboard bench for addend_vector_loader.
// Revision : 1.0
// ============================================================================
module tb_addend_vector_loader;

    localparam int DW  = 5;
    localparam int LEN = 9;
    localparam int OW  = DW + $clog2(LEN);
    localparam int CW  = $clog2(LEN + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic signed [DW-1:0] in_sample;
    logic                 in_sample_valid;
    logic                 out_sample_ready;
    logic                 in_flush;
    logic signed [DW-1:0] out_addends [LEN];
    logic signed [OW-1:0] out_running_sum;
    logic [CW-1:0]        out_count;
    logic                 out_vector_valid;
    logic                 in_vector_ready;

    addend_vector_loader #(
        .DATA_WIDTH(DW),
        .LENGTH    (LEN),
        .OUT_WIDTH (OW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_sample       (in_sample),
        .in_sample_valid (in_sample_valid),
        .out_sample_ready(out_sample_ready),
        .in_flush        (in_flush),
        .out_addends     (out_addends),
        .out_running_sum (out_running_sum),
        .out_count       (out_count),
        .out_vector_valid(out_vector_valid),
        .in_vector_ready (in_vector_ready)
    );

    int checks  = 0;
    int errors  = 0;
    int exp_q[$];
    int m_count = 0;
    int m_sum   = 0;
    bit m_full  = 1'b0;
    int vectors = 0;

    task automatic check(input string tag, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_cleared();
        for (int i = 0; i < LEN; i++) begin
            check("rst_addend", out_addends[i], 0);
        end
    endtask

    // One clock: drive at the falling edge, predict, then check after the rise.
    task automatic cycle(input bit v, input int s, input bit vr, input bit fl, input bit r);
        logic signed [DW-1:0] smp;
        int tsum;
        int esum;
        int e;
        smp             = DW'(s);
        rst             = r;
        in_flush        = fl;
        in_sample_valid = v;
        in_sample       = smp;
        in_vector_ready = vr;
        #1;
        check("ready", out_sample_ready, (!r && !fl && !m_full));
        if (r || fl) begin
            repeat (m_count) void'(exp_q.pop_back());
            m_count = 0;
            m_sum   = 0;
            m_full  = 1'b0;
        end else if (m_full) begin
            if (vr) begin
                tsum = 0;
                esum = 0;
                for (int i = 0; i < LEN; i++) begin
                    e = exp_q.pop_front();
                    check("addend", out_addends[i], e);
                    tsum += out_addends[i];
                    esum += e;
                end
                check("vec_sum", out_running_sum, esum);
                check("tree_sum", tsum, esum);
                vectors++;
                m_count = 0;
                m_sum   = 0;
                m_full  = 1'b0;
            end
        end else if (v) begin
            exp_q.push_back(int'(smp));
            m_sum += int'(smp);
            m_count++;
            if (m_count == LEN) m_full = 1'b1;
        end
        @(negedge clk);
        check("count", out_count, m_count);
        check("valid", out_vector_valid, m_full);
        check("sum", out_running_sum, m_sum);
    endtask

    initial begin
        int pat [LEN];
        int start;
        int cyc;
        pat = '{1, -2, 3, -4, 5, -6, 7, -8, 9};

        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        check_cleared();

        // Alternating-sign stream with downstream always ready
        for (int i = 0; i < LEN; i++) cycle(1, pat[i], 1, 0, 0);
        check("pattern_sum", out_running_sum, 5);
        cycle(0, 0, 1, 0, 0);

        // Back-pressure while FULL, then most-negative and most-positive vectors
        for (int i = 0; i < LEN; i++) cycle(1, -16, 0, 0, 0);
        check("neg_sum", out_running_sum, -144);
        repeat (5) cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0);
        for (int i = 0; i < LEN; i++) cycle(1, 15, 0, 0, 0);
        check("pos_sum", out_running_sum, 135);
        cycle(0, 0, 1, 0, 0);

        // Flush mid-fill with a sample offered
        repeat (4) cycle(1, 3, 0, 0, 0);
        cycle(1, 3, 0, 1, 0);
        for (int i = 0; i < LEN; i++) cycle(1, 1, 0, 0, 0);
        check("ones_sum", out_running_sum, 9);
        cycle(0, 0, 1, 0, 0);

        // Flush while FULL beats a simultaneous vector accept
        for (int i = 0; i < LEN; i++) cycle(1, 2, 0, 0, 0);
        cycle(1, 2, 1, 1, 0);

        // Reset after six accepts, then refill from slot 0
        for (int i = 0; i < 6; i++) cycle(1, i + 1, 0, 0, 0);
        cycle(1, 7, 0, 0, 1);
        check_cleared();
        for (int i = 0; i < LEN; i++) cycle(1, -i, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);

        // Reset while FULL
        for (int i = 0; i < LEN; i++) cycle(1, 4, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        check_cleared();

        // Random valid/ready gaps over 50 vectors
        start = vectors;
        cyc   = 0;
        while ((vectors - start) < 50 && cyc < 20000) begin
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)),
                  $urandom_range(0, 2) != 0, 0, 0);
            cyc++;
        end
        check("random_vectors", vectors - start, 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
